// File: rtl/level_countdown_if.sv
// Bundle of level_countdown control inputs and display/status outputs.
// The game side drives through master; the timer uses slave.
interface level_countdown_if;
    logic [7:0]  cur_level;
    logic        load;
    logic        start;
    logic        pause;
    logic        penalty;
    logic [11:0] sec_bcd;
    logic        running;
    logic        expired;
    logic        tick;

    modport master (
        output cur_level, load, start, pause, penalty,
        input  sec_bcd, running, expired, tick
    );

    modport slave (
        input  cur_level, load, start, pause, penalty,
        output sec_bcd, running, expired, tick
    );
endinterface

// File: rtl/level_countdown.sv
// Bomb-phase countdown: level-dependent start time with a floor, 1 Hz decrement,
// pause and penalty handling, and BCD output for the seven-segment driver.
module level_countdown #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned BASE_SECONDS    = 90,
    parameter int unsigned STEP_SECONDS    = 10,
    parameter int unsigned MIN_SECONDS     = 20,
    parameter int unsigned PENALTY_SECONDS = 5
) (
    input  logic               clk,
    input  logic               reset,
    level_countdown_if.slave   bus
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [15:0]   STEP16     = 16'(STEP_SECONDS);
    localparam logic [15:0]   FLOOR_AT   = 16'(BASE_SECONDS - MIN_SECONDS + 1);
    localparam logic [7:0]    BASE8      = 8'(BASE_SECONDS);
    localparam logic [7:0]    MIN8       = 8'(MIN_SECONDS);
    localparam logic [7:0]    PENALTY8   = 8'(PENALTY_SECONDS);

    typedef enum logic [2:0] {
        IDLE,
        LOADED,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    state_t        state, state_n;
    logic [7:0]    seconds, seconds_n;
    logic [PW-1:0] presc, presc_n;
    logic          tick_q, tick_n;

    logic [15:0]   product;
    logic [7:0]    start_val;
    logic          counting;
    logic          dec;
    logic [7:0]    sub;

    // Product is below FLOOR_AT on the subtract path, so its low byte is exact.
    assign product   = STEP16 * {8'd0, bus.cur_level};
    assign start_val = (product >= FLOOR_AT) ? MIN8 : (BASE8 - product[7:0]);

    // The release edge of a pause already counts, so K paused cycles cost exactly K.
    assign counting = ((state == RUN) || (state == PAUSED)) && !bus.pause;
    assign dec      = counting && (presc == PRESC_MAX);
    assign sub      = {7'd0, dec} + (bus.penalty ? PENALTY8 : 8'd0);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_n   = state;
        seconds_n = seconds;
        presc_n   = presc;
        tick_n    = 1'b0;

        if (bus.load) begin
            state_n   = LOADED;
            seconds_n = start_val;
            presc_n   = '0;
        end else begin
            unique case (state)
                LOADED: begin
                    if (bus.start) state_n = bus.pause ? PAUSED : RUN;
                end
                RUN, PAUSED: begin
                    state_n = counting ? RUN : PAUSED;
                    if (counting) presc_n = dec ? '0 : presc + 1'b1;
                    tick_n    = dec;
                    seconds_n = (seconds > sub) ? (seconds - sub) : 8'd0;
                    if (seconds_n == 8'd0) state_n = EXPIRED;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            seconds <= 8'd0;
            presc   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state   <= state_n;
            seconds <= seconds_n;
            presc   <= presc_n;
            tick_q  <= tick_n;
        end
    end

    // Double-dabble: add 3 to any digit >= 5, then shift in the next binary bit.
    logic [11:0] bcd;
    always_comb begin
        bcd = 12'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[3:0]  >= 4'd5) bcd[3:0]  = bcd[3:0]  + 4'd3;
            if (bcd[7:4]  >= 4'd5) bcd[7:4]  = bcd[7:4]  + 4'd3;
            if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], seconds[i]};
        end
    end

    assign bus.sec_bcd = bcd;
    assign bus.running = (state == RUN);
    assign bus.expired = (state == EXPIRED);
    assign bus.tick    = tick_q;

endmodule

// File: doc/level_countdown.md
# level_countdown

Per-user countdown timer for the bomb phase, downstream of the RAM controller. It takes the 8-bit `cur_level` that controller produces and computes a starting time: the higher the level, the less time, with a floor. It then counts down once per second and reports the remaining seconds as BCD digits for the seven-segment driver, plus an expiry flag for the game controller.

## Interface
- `CLK_HZ`, 50_000_000: clock cycles per second tick.
- `BASE_SECONDS`, 90: start time at level 0 (1..255).
- `STEP_SECONDS`, 10: seconds removed per level.
- `MIN_SECONDS`, 20: floor on start time (1..`BASE_SECONDS`).
- `PENALTY_SECONDS`, 5: seconds removed per `penalty` pulse.

Ports:
- `clk` in 1: on-board clock.
- `reset` in 1: synchronous, active-high reset.
- `cur_level` in 8: level from the RAM controller, sampled only on `load`.
- `load` in 1: one-cycle pulse that computes and loads the start time.
- `start` in 1: one-cycle pulse that begins the countdown.
- `pause` in 1: level; freezes the countdown while high.
- `penalty` in 1: one-cycle pulse; wrong-wire time penalty.
- `sec_bcd` out 12: remaining seconds as {hundreds, tens, ones} BCD.
- `running` out 1: high in RUN only.
- `expired` out 1: sticky; high in EXPIRED.
- `tick` out 1: one-cycle pulse on each per-second decrement.

## Operation
- Internal state: 8-bit `seconds` register, a prescaler counting 0..`CLK_HZ`-1, and an FSM.
- FSM states: IDLE, LOADED, RUN, PAUSED, EXPIRED.
- Reset values: FSM = IDLE, `seconds` = 0, prescaler = 0, `sec_bcd` = 12'h000, `running` = 0, `expired` = 0, `tick` = 0.
- Start time computation:
  - p = `STEP_SECONDS` × `cur_level`, computed at 16 bits.
  - If p ≥ `BASE_SECONDS` − `MIN_SECONDS` + 1, start = `MIN_SECONDS`.
  - Otherwise start = `BASE_SECONDS` − p, which is never below `MIN_SECONDS`.
  - The result is 8 bits; no intermediate overflow is permitted.
- Transitions:
  - `load` in any state → LOADED. `seconds` = start, prescaler = 0, `expired` cleared.
  - LOADED + `start` → RUN; if `pause` is high in that same cycle → PAUSED.
  - RUN + `pause` → PAUSED. While paused the prescaler holds its value and is not cleared.
  - PAUSED + !`pause` → RUN, with the prescaler resuming from its held value.
  - In RUN, when the prescaler reaches `CLK_HZ`-1 it wraps to 0, `seconds` decrements by 1 and `tick` fires.
  - RUN with `seconds` reaching 0 by any means → EXPIRED: `expired` = 1, `running` = 0.
  - EXPIRED holds until `load` or `reset`.
- Penalty:
  - Applies in RUN and PAUSED only; ignored in IDLE, LOADED and EXPIRED.
  - Subtracts `PENALTY_SECONDS` with saturation at 0.
  - Reaching 0 while PAUSED also moves to EXPIRED.
- Simultaneous events:
  - Tick and penalty in the same cycle subtract 1 + `PENALTY_SECONDS`, saturating, and `tick` still pulses.
  - Priority order is `reset` > `load` > `start` > `pause`/`penalty`/tick.
  - `start` outside LOADED is ignored.
- `sec_bcd` is a combinational binary-to-BCD conversion of `seconds` (0..255 → 3 digits).
- Reset mid-countdown returns everything to reset values on the next edge; no residual tick is allowed.

## Timing
- `load` sampled at edge N: `seconds`/`sec_bcd` show the start value from N+1, state is LOADED.
- `start` at edge N: `running` = 1 from N+1. The first decrement occurs at edge N+`CLK_HZ`, and subsequent decrements follow every `CLK_HZ` cycles of RUN.
- `tick` is registered: high for exactly the one cycle in which `seconds` first shows the decremented value.
- A pause of K cycles delays every following tick by exactly K cycles.
- `penalty` at edge N: the reduced value is visible from N+1.
- `expired` rises in the same cycle `seconds` first reads 0. No tick pulses occur after expiry.

## Test plan
All scenarios use `CLK_HZ`=4 with the other parameters at their defaults.
- Reset then `load` with `cur_level`=3 → `sec_bcd`=12'h060 next cycle, `running`=0, `expired`=0.
- `load` with `cur_level`=7 → 20; with `cur_level`=200 → 20, the 16-bit product saturating to the floor; with `cur_level`=0 → 90.
- `load` `cur_level`=8 (start 20), then `start` → `tick` every 4 cycles, `sec_bcd` steps 020, 019, …. After 80 cycles `sec_bcd`=000 and `expired`=1; no further ticks.
- While running at 12, hold `pause` for 10 cycles → no decrement during the pause; the next tick arrives 10 cycles late. A `penalty` during the pause → 7.
- At 3 seconds, assert `penalty` in the tick cycle → `seconds`=0, `tick`=1, `expired`=1 on the same cycle.
- Assert `reset` mid-RUN → all outputs return to reset values next cycle. `start` in IDLE is ignored. `load` during EXPIRED clears `expired` and reloads the start time.
